cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between the two result producers, the ALU and the load/store buffer.
- Each source gets a small result FIFO. Arbitration between sources is round-robin. At most one broadcast per cycle reaches the reservation station, LSB and RoB wake-up logic.
- Provides full back-pressure so the RS can stop dispatching to the ALU and the LSB can stop completing.

---
 rtl/cdb_arbiter_if.sv | 35 +++
 rtl/cdb_arbiter.sv | 145 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Result-producer and CDB broadcast bundle for cdb_arbiter.
// slave = arbiter side, master = producers / consumers.
interface cdb_arbiter_if #(
   parameter int ROB_ADDR = 4
);
   logic                alu_valid;
   logic [ROB_ADDR-1:0] alu_robid;
   logic [31:0]         alu_val;
   logic                alu_full;
   logic                lsb_valid;
   logic [ROB_ADDR-1:0] lsb_robid;
   logic [31:0]         lsb_val;
   logic                lsb_full;
   logic                cdb_valid;
   logic [ROB_ADDR-1:0] cdb_robid;
   logic [31:0]         cdb_val;
   logic                cdb_src;
   logic                overflow_err;

   modport slave (
      input  alu_valid, alu_robid, alu_val,
      input  lsb_valid, lsb_robid, lsb_val,
      output alu_full, lsb_full,
      output cdb_valid, cdb_robid, cdb_val, cdb_src,
      output overflow_err
   );

   modport master (
      output alu_valid, alu_robid, alu_val,
      output lsb_valid, lsb_robid, lsb_val,
      input  alu_full, lsb_full,
      input  cdb_valid, cdb_robid, cdb_val, cdb_src,
      input  overflow_err
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs with empty bypass,
// round-robin grant between ALU (0) and LSB (1), one broadcast per cycle.
module cdb_arbiter #(
   parameter int ROB_ADDR   = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_ADDR  = 2
) (
   input  logic          clk_in,
   input  logic          rst_n_in,
   input  logic          rdy_in,
   input  logic          rob_clear,
   cdb_arbiter_if.slave  bus
);
   localparam logic [FIFO_ADDR:0]   CNT_MAX = (FIFO_ADDR+1)'(FIFO_DEPTH);
   localparam logic [FIFO_ADDR:0]   CNT_HI  = (FIFO_ADDR+1)'(FIFO_DEPTH-1);
   localparam logic [FIFO_ADDR:0]   CNT_ONE = (FIFO_ADDR+1)'(1);
   localparam logic [FIFO_ADDR-1:0] PTR_ONE = FIFO_ADDR'(1);

   logic [1:0]          in_v;
   logic [ROB_ADDR-1:0] in_tag [2];
   logic [31:0]         in_val [2];

   logic [ROB_ADDR-1:0]  q_tag  [2][FIFO_DEPTH];
   logic [31:0]          q_val  [2][FIFO_DEPTH];
   logic [FIFO_ADDR-1:0] rd_ptr [2];
   logic [FIFO_ADDR-1:0] wr_ptr [2];
   logic [FIFO_ADDR:0]   cnt    [2];

   logic [1:0]          head, cand, gnt, pop, push, drop;
   logic                sel;
   logic [ROB_ADDR-1:0] sel_tag;
   logic [31:0]         sel_val;
   logic                last_grant;

   logic                cdb_valid_q;
   logic [ROB_ADDR-1:0] cdb_robid_q;
   logic [31:0]         cdb_val_q;
   logic                cdb_src_q;
   logic                overflow_q;

   assign in_v      = {bus.lsb_valid, bus.alu_valid};
   assign in_tag[0] = bus.alu_robid;
   assign in_tag[1] = bus.lsb_robid;
   assign in_val[0] = bus.alu_val;
   assign in_val[1] = bus.lsb_val;

   assign bus.alu_full     = (cnt[0] >= CNT_HI);
   assign bus.lsb_full     = (cnt[1] >= CNT_HI);
   assign bus.cdb_valid    = cdb_valid_q;
   assign bus.cdb_robid    = cdb_robid_q;
   assign bus.cdb_val      = cdb_val_q;
   assign bus.cdb_src      = cdb_src_q;
   assign bus.overflow_err = overflow_q;

   // Candidate selection, round-robin grant and FIFO push/pop decisions.
   always_comb begin
      head    = '0;
      cand    = '0;
      gnt     = '0;
      pop     = '0;
      push    = '0;
      drop    = '0;
      sel     = 1'b0;
      sel_tag = '0;
      sel_val = '0;
      for (int i = 0; i < 2; i++) begin
         head[i] = (cnt[i] != '0);
         cand[i] = head[i] | in_v[i];
      end
      gnt[0] = cand[0] & (~cand[1] | last_grant);
      gnt[1] = cand[1] & (~cand[0] | ~last_grant);
      for (int i = 0; i < 2; i++) begin
         pop[i]  = gnt[i] & head[i];
         push[i] = in_v[i] & ~(gnt[i] & ~head[i])
                 & ((cnt[i] != CNT_MAX) | pop[i]);
         drop[i] = in_v[i] & (cnt[i] == CNT_MAX) & ~pop[i];
      end
      sel = gnt[1];
      if (head[sel]) begin
         sel_tag = q_tag[sel][rd_ptr[sel]];
         sel_val = q_val[sel][rd_ptr[sel]];
      end else begin
         sel_tag = in_tag[sel];
         sel_val = in_val[sel];
      end
   end

   // Control state: pointers, counts, broadcast register, grant history.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < 2; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            cnt[i]    <= '0;
         end
         cdb_valid_q <= 1'b0;
         cdb_robid_q <= '0;
         cdb_val_q   <= '0;
         cdb_src_q   <= 1'b0;
         overflow_q  <= 1'b0;
         last_grant  <= 1'b1;
      end else if (rdy_in) begin
         if (rob_clear) begin
            for (int i = 0; i < 2; i++) begin
               rd_ptr[i] <= '0;
               wr_ptr[i] <= '0;
               cnt[i]    <= '0;
            end
            cdb_valid_q <= 1'b0;
         end else begin
            cdb_valid_q <= |gnt;
            if (|gnt) begin
               cdb_robid_q <= sel_tag;
               cdb_val_q   <= sel_val;
               cdb_src_q   <= sel;
               last_grant  <= sel;
            end
            for (int i = 0; i < 2; i++) begin
               if (pop[i])
                  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
               if (push[i])
                  wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
               if (push[i] && !pop[i])
                  cnt[i] <= cnt[i] + CNT_ONE;
               else if (pop[i] && !push[i])
                  cnt[i] <= cnt[i] - CNT_ONE;
            end
            if (|drop)
               overflow_q <= 1'b1;
         end
      end
   end

   // FIFO storage; contents need no reset since counts gate every read.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !rob_clear) begin
         for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
               q_tag[i][wr_ptr[i]] <= in_tag[i];
               q_val[i][wr_ptr[i]] <= in_val[i];
            end
         end
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, bypass, contention,
// alternation, overflow, flush, stall and async reset.
module tb_cdb_arbiter;
   logic clk_in    = 1'b0;
   logic rst_n_in  = 1'b0;
   logic rdy_in    = 1'b1;
   logic rob_clear = 1'b0;
   int   n_cmp     = 0;
   int   n_bad     = 0;

   cdb_arbiter_if #(.ROB_ADDR(4)) bus ();

   cdb_arbiter #(
      .ROB_ADDR(4), .FIFO_DEPTH(4), .FIFO_ADDR(2)
   ) dut (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .rdy_in(rdy_in),
      .rob_clear(rob_clear),
      .bus(bus.slave)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [37:0] pk(input logic v, input logic s,
                                      input logic [3:0] t);
      logic [31:0] val;
      val = (s ? 32'hB000_0000 : 32'hA000_0000) | 32'(t);
      return {v, s, t, val};
   endfunction

   function automatic logic [37:0] got();
      return {bus.cdb_valid, bus.cdb_src, bus.cdb_robid, bus.cdb_val};
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic av, input logic [3:0] at,
                        input logic lv, input logic [3:0] lt);
      bus.alu_valid = av;
      bus.alu_robid = at;
      bus.alu_val   = 32'hA000_0000 | 32'(at);
      bus.lsb_valid = lv;
      bus.lsb_robid = lt;
      bus.lsb_val   = 32'hB000_0000 | 32'(lt);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0);
      rob_clear = 1'b0;
      rdy_in    = 1'b1;
      rst_n_in  = 1'b0;
      #3;
      @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
   endtask

   task automatic fill_six();
      for (int s = 0; s < 6; s++) begin
         drive(1, 4'(s), 1, 4'(8 + s));
         step();
      end
      drive(0, 0, 0, 0);
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0);
      #2;
      n_cmp++;
      if (got() !== 38'h0) begin
         n_bad++;
         $display("FAIL reset_cdb got=%h exp=%h", got(), 38'h0);
      end
      n_cmp++;
      if ({bus.overflow_err, bus.alu_full, bus.lsb_full} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_flags got=%b exp=000",
                  {bus.overflow_err, bus.alu_full, bus.lsb_full});
      end
      @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
   endtask

   task automatic test_single();
      logic [37:0] e;
      drive(1, 3, 0, 0);
      bus.alu_val = 32'h1234_5678;
      step();
      e = {1'b1, 1'b0, 4'd3, 32'h1234_5678};
      n_cmp++;
      if (got() !== e) begin
         n_bad++;
         $display("FAIL single_bcast got=%h exp=%h", got(), e);
      end
      drive(0, 0, 0, 0);
      step();
      e = {1'b0, 1'b0, 4'd3, 32'h1234_5678};
      n_cmp++;
      if (got() !== e) begin
         n_bad++;
         $display("FAIL single_idle got=%h exp=%h", got(), e);
      end
   endtask

   task automatic test_simultaneous();
      logic [37:0] e;
      do_reset();
      drive(1, 1, 1, 2);
      bus.alu_val = 32'hA;
      bus.lsb_val = 32'hB;
      step();
      e = {1'b1, 1'b0, 4'd1, 32'hA};
      n_cmp++;
      if (got() !== e) begin
         n_bad++;
         $display("FAIL simul_alu got=%h exp=%h", got(), e);
      end
      drive(0, 0, 0, 0);
      step();
      e = {1'b1, 1'b1, 4'd2, 32'hB};
      n_cmp++;
      if (got() !== e) begin
         n_bad++;
         $display("FAIL simul_lsb got=%h exp=%h", got(), e);
      end
      step();
      e = {1'b0, 1'b1, 4'd2, 32'hB};
      n_cmp++;
      if (got() !== e) begin
         n_bad++;
         $display("FAIL simul_drained got=%h exp=%h", got(), e);
      end
   endtask

   task automatic test_alternate();
      logic [11:0] af_exp;
      logic [11:0] lf_exp;
      logic [37:0] e;
      logic        s_src;
      logic [3:0]  s_tag;
      af_exp = 12'h020;
      lf_exp = 12'h070;
      do_reset();
      for (int s = 0; s < 12; s++) begin
         if (s < 6) drive(1, 4'(s), 1, 4'(8 + s));
         else       drive(0, 0, 0, 0);
         step();
         s_src = (s % 2) == 1;
         s_tag = s_src ? 4'(8 + s / 2) : 4'(s / 2);
         e = pk(1'b1, s_src, s_tag);
         n_cmp++;
         if (got() !== e) begin
            n_bad++;
            $display("FAIL alt_bcast[%0d] got=%h exp=%h", s, got(), e);
         end
         n_cmp++;
         if ({bus.alu_full, bus.lsb_full} !== {af_exp[s], lf_exp[s]}) begin
            n_bad++;
            $display("FAIL alt_full[%0d] got=%b exp=%b", s,
                     {bus.alu_full, bus.lsb_full}, {af_exp[s], lf_exp[s]});
         end
      end
      step();
      n_cmp++;
      if ({bus.cdb_valid, bus.overflow_err} !== 2'b00) begin
         n_bad++;
         $display("FAIL alt_end got=%b exp=00",
                  {bus.cdb_valid, bus.overflow_err});
      end
   endtask

   task automatic test_overflow();
      int          exp_tag [14];
      logic [13:0] exp_src;
      logic [37:0] e;
      exp_tag = '{0, 10, 1, 11, 2, 12, 3, 13, 4, 14, 5, 6, 7, 8};
      exp_src = 14'b00_0010_1010_1010;
      do_reset();
      for (int c = 0; c < 14; c++) begin
         if (c < 10) drive(1, 4'(c), (c % 2) == 0, 4'(10 + c / 2));
         else        drive(0, 0, 0, 0);
         step();
         e = pk(1'b1, exp_src[c], 4'(exp_tag[c]));
         n_cmp++;
         if (got() !== e) begin
            n_bad++;
            $display("FAIL ovf_bcast[%0d] got=%h exp=%h", c, got(), e);
         end
         n_cmp++;
         if (bus.overflow_err !== (c >= 9)) begin
            n_bad++;
            $display("FAIL ovf_flag[%0d] got=%b exp=%b", c,
                     bus.overflow_err, c >= 9);
         end
      end
      step();
      n_cmp++;
      if (bus.cdb_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_dropped got=%b exp=0", bus.cdb_valid);
      end
   endtask

   task automatic test_clear();
      logic [37:0] e;
      do_reset();
      fill_six();
      rob_clear = 1'b1;
      drive(1, 15, 1, 15);
      step();
      rob_clear = 1'b0;
      n_cmp++;
      if ({bus.cdb_valid, bus.alu_full, bus.lsb_full} !== 3'b000) begin
         n_bad++;
         $display("FAIL clear_state got=%b exp=000",
                  {bus.cdb_valid, bus.alu_full, bus.lsb_full});
      end
      drive(1, 7, 0, 0);
      step();
      e = pk(1'b1, 1'b0, 4'd7);
      n_cmp++;
      if (got() !== e) begin
         n_bad++;
         $display("FAIL clear_fresh got=%h exp=%h", got(), e);
      end
      drive(0, 0, 0, 0);
      step();
      n_cmp++;
      if (bus.cdb_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL clear_empty got=%b exp=0", bus.cdb_valid);
      end
   endtask

   task automatic test_stall_and_reset();
      logic [37:0] e;
      do_reset();
      fill_six();
      rdy_in = 1'b0;
      drive(1, 9, 1, 9);
      e = pk(1'b1, 1'b1, 4'd10);
      for (int k = 0; k < 3; k++) begin
         step();
         n_cmp++;
         if (got() !== e) begin
            n_bad++;
            $display("FAIL stall_hold[%0d] got=%h exp=%h", k, got(), e);
         end
         n_cmp++;
         if ({bus.alu_full, bus.lsb_full} !== 2'b11) begin
            n_bad++;
            $display("FAIL stall_full[%0d] got=%b exp=11", k,
                     {bus.alu_full, bus.lsb_full});
         end
      end
      rdy_in = 1'b1;
      drive(0, 0, 0, 0);
      step();
      e = pk(1'b1, 1'b0, 4'd3);
      n_cmp++;
      if (got() !== e) begin
         n_bad++;
         $display("FAIL resume_alu got=%h exp=%h", got(), e);
      end
      step();
      e = pk(1'b1, 1'b1, 4'd11);
      n_cmp++;
      if (got() !== e) begin
         n_bad++;
         $display("FAIL resume_lsb got=%h exp=%h", got(), e);
      end
      #3;
      rst_n_in = 1'b0;
      #1;
      n_cmp++;
      if (got() !== 38'h0) begin
         n_bad++;
         $display("FAIL async_rst_cdb got=%h exp=%h", got(), 38'h0);
      end
      n_cmp++;
      if ({bus.overflow_err, bus.alu_full, bus.lsb_full} !== 3'b000) begin
         n_bad++;
         $display("FAIL async_rst_flags got=%b exp=000",
                  {bus.overflow_err, bus.alu_full, bus.lsb_full});
      end
      @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
      step();
      n_cmp++;
      if (bus.cdb_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL async_rst_lost got=%b exp=0", bus.cdb_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_alternate();
      test_overflow();
      test_clear();
      test_stall_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
